decimal_entry_loader: RTL and testbench



---
 rtl/decimal_entry_loader.sv | 190 +++++++++++++++++++
 tb/tb_decimal_entry_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decimal_entry_loader.sv
// decimal_entry_loader: two-button decimal entry front end for the mod-16 counter.
// The user edits a tens digit (0-1) and a units digit (0-9). A confirmation converts
// the entry to 4-bit binary and issues a one-cycle active-low parallel-load strobe.
//
// Build option: define DECIMAL_ENTRY_ERR_EN to flag entries 16-19 on err and stay
// in EDIT_UNITS for correction. Without it, such entries saturate and load 4'd15.
//
// Press contract: each debouncer emits press_o as a single-cycle pulse. There is no
// backpressure; a pulse that arrives while the FSM cannot use it is simply dropped.

// Synchronizer plus debouncer for one raw push-button, producing a press pulse.
module decimal_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       acc_q, acc_d;
  logic       acc_dly_q;
  logic       press_q;
  logic [7:0] cnt_q, cnt_d;

  // Count consecutive disagreements; accept the new level on the last one.
  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (sync2_q != acc_q) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Synchronizer, accepted level, its delayed copy and the registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      acc_q     <= 1'b0;
      acc_dly_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      acc_q     <= acc_d;
      acc_dly_q <= acc_q;
      cnt_q     <= cnt_d;
      press_q   <= acc_q & ~acc_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// Top level: two button front ends feeding the digit-entry FSM.
module decimal_entry_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_next,
  output logic [3:0] data,
  output logic       pl_n,
  output logic [3:0] tens_bcd,
  output logic [3:0] unit_bcd,
  output logic       digit_sel,
  output logic       err,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_EDIT_TENS  = 2'd0,
    S_EDIT_UNITS = 2'd1,
    S_LOAD       = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] unit_q, unit_d;
  logic [3:0] data_q, data_d;
  logic       pl_n_q, pl_n_d;
  logic       err_q, err_d;
  logic       inc_p, next_p;
  logic [4:0] value;

  decimal_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_inc),
    .press_o (inc_p)
  );

  decimal_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_next),
    .press_o (next_p)
  );

  // Two-digit decimal entry as a 5-bit binary value (0..19).
  assign value = {1'b0, unit_q} + (tens_q[0] ? 5'd10 : 5'd0);

  // Next-state and registered-output logic; next beats inc, LOAD ignores pulses.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    unit_d  = unit_q;
    data_d  = data_q;
    pl_n_d  = 1'b1;
    err_d   = err_q;
    case (state_q)
      S_EDIT_TENS: begin
        if (next_p) begin
          state_d = S_EDIT_UNITS;
          err_d   = 1'b0;
        end else if (inc_p) begin
          tens_d = {3'b000, ~tens_q[0]};
          err_d  = 1'b0;
        end
      end
      S_EDIT_UNITS: begin
        if (next_p) begin
          err_d = 1'b0;
          if (value <= 5'd15) begin
            state_d = S_LOAD;
            data_d  = value[3:0];
            pl_n_d  = 1'b0;
          end else begin
`ifdef DECIMAL_ENTRY_ERR_EN
            err_d = 1'b1;
`else
            state_d = S_LOAD;
            data_d  = 4'd15;
            pl_n_d  = 1'b0;
`endif
          end
        end else if (inc_p) begin
          unit_d = (unit_q == 4'd9) ? 4'd0 : unit_q + 4'd1;
          err_d  = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_EDIT_TENS;
      end
      default: begin
        state_d = S_EDIT_TENS;
      end
    endcase
  end

  // State and output registers; reset aborts any debounce or load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EDIT_TENS;
      tens_q  <= '0;
      unit_q  <= '0;
      data_q  <= '0;
      pl_n_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      unit_q  <= unit_d;
      data_q  <= data_d;
      pl_n_q  <= pl_n_d;
      err_q   <= err_d;
    end
  end

  assign data        = data_q;
  assign pl_n        = pl_n_q;
  assign tens_bcd    = tens_q;
  assign unit_bcd    = unit_q;
  assign digit_sel   = (state_q == S_EDIT_UNITS);
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_decimal_entry_loader.sv
// Testbench for decimal_entry_loader with DEBOUNCE_CYCLES = 4. A cycle-level
// reference model built from sample-history windows and plain digit arithmetic
// is compared against the outputs on every falling edge; directed scenarios add
// fixed expectations for the notable cases.
module tb_decimal_entry_loader;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_next = 1'b0;
  wire  [3:0] data;
  wire        pl_n;
  wire  [3:0] tens_bcd;
  wire  [3:0] unit_bcd;
  wire        digit_sel;
  wire        err;
  wire  [1:0] dbg_state;

  decimal_entry_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_inc     (btn_inc),
    .btn_next    (btn_next),
    .data        (data),
    .pl_n        (pl_n),
    .tens_bcd    (tens_bcd),
    .unit_bcd    (unit_bcd),
    .digit_sel   (digit_sel),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Button path: sample history windows. The debouncer sees the raw level from two
  // edges earlier; the accepted level flips once the last N seen samples all differ;
  // the FSM acts on a press two edges after the accepted level rose.
  logic [31:0] raw_h [2];
  logic [31:0] syn_h [2];
  logic [31:0] acc_h [2];
  logic        m_acc [2];
  int          m_state = 0;   // 0 tens, 1 units, 2 load
  int          m_tens  = 0;
  int          m_units = 0;
  int          m_data  = 0;
  logic        m_pl_n  = 1'b1;
  logic        m_err   = 1'b0;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      raw_h[b] = '0;
      syn_h[b] = '0;
      acc_h[b] = '0;
      m_acc[b] = 1'b0;
    end
    m_state = 0;
    m_tens  = 0;
    m_units = 0;
    m_data  = 0;
    m_pl_n  = 1'b1;
    m_err   = 1'b0;
  endtask

  task automatic model_btn(input int b, input logic raw, output logic pulse);
    logic synced;
    bit   all_diff;
    raw_h[b] = {raw_h[b][30:0], raw};
    synced   = raw_h[b][2];
    syn_h[b] = {syn_h[b][30:0], synced};
    all_diff = 1'b1;
    for (int i = 0; i < N; i++)
      if (syn_h[b][i] == m_acc[b]) all_diff = 1'b0;
    if (all_diff) m_acc[b] = synced;
    acc_h[b] = {acc_h[b][30:0], m_acc[b]};
    pulse    = acc_h[b][2] & ~acc_h[b][3];
  endtask

  task automatic model_step();
    logic p_inc, p_next;
    int   v;
    model_btn(0, btn_inc, p_inc);
    model_btn(1, btn_next, p_next);
    m_pl_n = 1'b1;
    if (m_state == 2) begin
      m_state = 0;
    end else if (p_next) begin
      m_err = 1'b0;
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        v = m_tens * 10 + m_units;
        if (v <= 15) begin
          m_data  = v;
          m_pl_n  = 1'b0;
          m_state = 2;
        end else begin
`ifdef DECIMAL_ENTRY_ERR_EN
          m_err = 1'b1;
`else
          m_data  = 15;
          m_pl_n  = 1'b0;
          m_state = 2;
`endif
        end
      end
    end else if (p_inc) begin
      m_err = 1'b0;
      if (m_state == 0) m_tens = 1 - m_tens;
      else              m_units = (m_units + 1) % 10;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("pl_n",      pl_n,      m_pl_n);
      check("data",      data,      m_data);
      check("tens",      tens_bcd,  m_tens);
      check("units",     unit_bcd,  m_units);
      check("digit_sel", digit_sel, m_state == 1);
      check("err",       err,       m_err);
    end
  end

  // Strobe monitor: counts low cycles of pl_n and remembers the loaded value.
  int       strobe_cnt  = 0;
  int       strobe_data = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && pl_n === 1'b0) begin
        strobe_cnt++;
        strobe_data = data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 inc, 1 next, 2 both
  task automatic press(input int which, input int hold, input int gap);
    if (which != 1) btn_inc  = 1'b1;
    if (which != 0) btn_next = 1'b1;
    step(hold);
    btn_inc  = 1'b0;
    btn_next = 1'b0;
    step(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pl_n"},  pl_n,      1);
    check({tag, "_data"},  data,      0);
    check({tag, "_tens"},  tens_bcd,  0);
    check({tag, "_units"}, unit_bcd,  0);
    check({tag, "_dsel"},  digit_sel, 0);
    check({tag, "_err"},   err,       0);
  endtask

  // ---------------- stimulus ----------------
  int  s0;
  bit  found;

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    step(3);
    @(negedge clk);
    rst = 1'b0;
    step(3);

    // Asynchronous reset in mid-cycle after some state has been built up.
    press(0, 10, 10);
    check("pre_rst_tens", tens_bcd, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    step(3);
    @(negedge clk);
    rst = 1'b0;
    step(2);

    // Enter "12".
    s0 = strobe_cnt;
    press(0, 10, 10);
    press(1, 10, 10);
    press(0, 10, 10);
    press(0, 10, 10);
    press(1, 10, 10);
    check("e12_strobes", strobe_cnt - s0, 1);
    check("e12_data",    strobe_data, 12);
    check("e12_tens",    tens_bcd, 1);
    check("e12_units",   unit_bcd, 2);
    check("e12_dsel",    digit_sel, 0);

    // Bounce on inc: must not register.
    btn_inc = 1'b1; step(3);
    btn_inc = 1'b0; step(1);
    btn_inc = 1'b1; step(2);
    btn_inc = 1'b0; step(10);
    check("bounce_tens", tens_bcd, 1);

    // Clean hold: pulse after edge E+6, digit visible after edge E+7.
    btn_inc = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("lat_pre", tens_bcd, 1);
    @(posedge clk);
    @(negedge clk);
    check("lat_post", tens_bcd, 0);
    step(12);
    btn_inc = 1'b0;
    step(10);
    check("hold_once", tens_bcd, 0);

    // Wrap tests.
    s0 = strobe_cnt;
    press(0, 8, 8);
    press(0, 8, 8);
    check("tens_wrap", tens_bcd, 0);
    press(1, 8, 8);
    for (int i = 0; i < 7; i++) press(0, 8, 8);
    check("units9", unit_bcd, 9);
    press(0, 8, 8);
    check("units_wrap", unit_bcd, 0);
    check("wrap_no_strobe", strobe_cnt - s0, 0);
    press(1, 8, 8);
    check("zero_strobe", strobe_cnt - s0, 1);
    check("zero_data", strobe_data, 0);

    // Invalid entry "17".
    press(0, 8, 8);
    press(1, 8, 8);
    for (int i = 0; i < 7; i++) press(0, 8, 8);
    check("e17_units", unit_bcd, 7);
    s0 = strobe_cnt;
    press(1, 8, 8);
`ifdef DECIMAL_ENTRY_ERR_EN
    check("e17_err",       err, 1);
    check("e17_no_strobe", strobe_cnt - s0, 0);
    check("e17_dsel",      digit_sel, 1);
    press(0, 8, 8);
    check("e17_err_clr", err, 0);
    check("e17_units8",  unit_bcd, 8);
    press(1, 8, 8);
    check("e18_err", err, 1);
    press(0, 8, 8);
    press(0, 8, 8);
    press(1, 8, 8);
    check("e10_strobe", strobe_cnt - s0, 1);
    check("e10_data",   strobe_data, 10);
`else
    check("e17_strobe", strobe_cnt - s0, 1);
    check("e17_data",   strobe_data, 15);
    check("e17_err",    err, 0);
    check("e17_dsel",   digit_sel, 0);
`endif

    // Simultaneous inc and next in EDIT_TENS: next wins.
    press(2, 8, 8);
    check("both_dsel", digit_sel, 1);
    check("both_tens", tens_bcd, 1);

    // Reset during the LOAD cycle.
    btn_next = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (pl_n === 1'b0) found = 1'b1;
    end
    check("load_seen", found, 1);
    btn_next = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("load_rst");
    step(2);
    @(negedge clk);
    rst = 1'b0;
    step(N + 6);

    // Randomized presses, glitches, simultaneous presses and occasional resets.
    for (int it = 0; it < 220; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        @(negedge clk);
        #2 rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
        step($urandom_range(1, 4));
      end else if (r < 48) begin
        press(0, $urandom_range(1, 12), $urandom_range(1, 12));
      end else if (r < 88) begin
        press(1, $urandom_range(1, 12), $urandom_range(1, 12));
      end else begin
        press(2, $urandom_range(1, 12), $urandom_range(1, 12));
      end
    end
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
